// File: rtl/gomoku_turn_ctrl.sv
// Five-in-a-row turn sequencer: owns the board and cursor, places stones and
// scans the four lines through each new stone for a win, then checks for a draw.
module gomoku_turn_ctrl #(
    parameter int BOARD_DIM = 16,
    parameter int WIN_LEN   = 5,
    localparam int CW = $clog2(BOARD_DIM)
) (
    input  logic                             Clck,
    input  logic                             Reset,
    input  logic                             btn_left,
    input  logic                             btn_right,
    input  logic                             btn_up,
    input  logic                             btn_down,
    input  logic                             btn_place,
    output logic [2*BOARD_DIM*BOARD_DIM-1:0] board,
    output logic [CW-1:0]                    pointer_loc_x,
    output logic [CW-1:0]                    pointer_loc_y,
    output logic [1:0]                       gaming_status,
    output logic                             current_player,
    output logic                             busy,
    output logic                             illegal
);
    localparam int CELLS = BOARD_DIM * BOARD_DIM;
    localparam int BW    = 2 * CELLS;
    localparam int MW    = $clog2(CELLS) + 1;
    localparam int RW    = $clog2(WIN_LEN + 1) + 1;
    // Two extra bits keep probe coordinates from origin-5 to origin+5 unaliased.
    localparam int SW    = CW + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_PLACE, S_FWD, S_BWD, S_EVAL, S_TURN, S_OVER
    } state_t;

    function automatic logic signed [SW-1:0] step_x(input logic [1:0] d);
        return (d == 2'd1) ? '0 : SW'(1);
    endfunction

    function automatic logic signed [SW-1:0] step_y(input logic [1:0] d);
        case (d)
            2'd0:    return '0;
            2'd3:    return '1;
            default: return SW'(1);
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [BW-1:0]         board_q, board_d;
    logic [CW-1:0]         cx_q, cx_d, cy_q, cy_d, ox_q, ox_d, oy_q, oy_d;
    logic signed [SW-1:0]  px_q, px_d, py_q, py_d;
    logic [1:0]            dir_q, dir_d, status_q, status_d;
    logic [RW-1:0]         run_q, run_d;
    logic [MW-1:0]         mcnt_q, mcnt_d;
    logic                  player_q, player_d, illegal_q, illegal_d;

    logic [1:0]            pcode, probe_cell, cur_cell;
    logic signed [SW-1:0]  cx_s, cy_s, ox_s, oy_s, sx, sy, nsx, nsy;
    logic                  in_bnd, hit;

    assign pcode      = player_q ? 2'b10 : 2'b01;
    assign cx_s       = {2'b00, cx_q};
    assign cy_s       = {2'b00, cy_q};
    assign ox_s       = {2'b00, ox_q};
    assign oy_s       = {2'b00, oy_q};
    assign sx         = step_x(dir_q);
    assign sy         = step_y(dir_q);
    assign nsx        = step_x(dir_q + 2'd1);
    assign nsy        = step_y(dir_q + 2'd1);
    // In bounds exactly when both coordinates are non-negative and below BOARD_DIM.
    assign in_bnd     = (px_q[SW-1:CW] == '0) && (py_q[SW-1:CW] == '0);
    assign probe_cell = board_q[{py_q[CW-1:0], px_q[CW-1:0], 1'b0} +: 2];
    assign cur_cell   = board_q[{cy_q, cx_q, 1'b0} +: 2];
    assign hit        = in_bnd && (probe_cell == pcode) && (run_q < RW'(WIN_LEN));

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        px_d      = px_q;
        py_d      = py_q;
        dir_d     = dir_q;
        run_d     = run_q;
        mcnt_d    = mcnt_q;
        status_d  = status_q;
        player_d  = player_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_place) begin
                    if (cur_cell != 2'b00) illegal_d = 1'b1;
                    else                   state_d   = S_PLACE;
                end else if (btn_left) begin
                    if (cx_q != '0) cx_d = cx_q - 1'b1;
                end else if (btn_right) begin
                    if (cx_q != CW'(BOARD_DIM - 1)) cx_d = cx_q + 1'b1;
                end else if (btn_up) begin
                    if (cy_q != '0) cy_d = cy_q - 1'b1;
                end else if (btn_down) begin
                    if (cy_q != CW'(BOARD_DIM - 1)) cy_d = cy_q + 1'b1;
                end
            end
            S_PLACE: begin
                board_d[{cy_q, cx_q, 1'b0} +: 2] = pcode;
                ox_d    = cx_q;
                oy_d    = cy_q;
                mcnt_d  = mcnt_q + 1'b1;
                dir_d   = 2'd0;
                run_d   = RW'(1);
                px_d    = cx_s + step_x(2'd0);
                py_d    = cy_s + step_y(2'd0);
                state_d = S_FWD;
            end
            S_FWD: begin
                if (hit) begin
                    run_d = run_q + 1'b1;
                    px_d  = px_q + sx;
                    py_d  = py_q + sy;
                end else begin
                    px_d    = ox_s - sx;
                    py_d    = oy_s - sy;
                    state_d = S_BWD;
                end
            end
            S_BWD: begin
                if (hit) begin
                    run_d = run_q + 1'b1;
                    px_d  = px_q - sx;
                    py_d  = py_q - sy;
                end else begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (run_q >= RW'(WIN_LEN)) begin
                    status_d = pcode;
                    state_d  = S_OVER;
                end else if (dir_q != 2'd3) begin
                    dir_d   = dir_q + 2'd1;
                    run_d   = RW'(1);
                    px_d    = ox_s + nsx;
                    py_d    = oy_s + nsy;
                    state_d = S_FWD;
                end else begin
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                // Reached only without a win, so a full board here is a draw.
                if (mcnt_q == MW'(CELLS)) begin
                    status_d = 2'b11;
                    state_d  = S_OVER;
                end else begin
                    player_d = ~player_q;
                    state_d  = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clck) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            board_q   <= '0;
            cx_q      <= CW'(BOARD_DIM / 2 - 1);
            cy_q      <= CW'(BOARD_DIM / 2 - 1);
            ox_q      <= '0;
            oy_q      <= '0;
            px_q      <= '0;
            py_q      <= '0;
            dir_q     <= '0;
            run_q     <= '0;
            mcnt_q    <= '0;
            status_q  <= 2'b00;
            player_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            px_q      <= px_d;
            py_q      <= py_d;
            dir_q     <= dir_d;
            run_q     <= run_d;
            mcnt_q    <= mcnt_d;
            status_q  <= status_d;
            player_q  <= player_d;
            illegal_q <= illegal_d;
        end
    end

    assign board          = board_q;
    assign pointer_loc_x  = cx_q;
    assign pointer_loc_y  = cy_q;
    assign gaming_status  = status_q;
    assign current_player = player_q;
    assign illegal        = illegal_q;
    assign busy           = state_q inside {S_PLACE, S_FWD, S_BWD, S_EVAL, S_TURN};

endmodule

// File: tb/tb_gomoku_turn_ctrl.sv
// Bench for gomoku_turn_ctrl: a board-array game model is compared against the
// DUT every idle cycle, plus literal checks on scripted games.
module tb_gomoku_turn_ctrl;
    localparam int N = 16;
    localparam logic [4:0] LEFT = 5'b00001, RIGHT = 5'b00010, UP = 5'b00100,
                           DOWN = 5'b01000, PLACE = 5'b10000;

    logic Clck = 1'b0;
    logic Reset = 1'b0;
    logic bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0, bp = 1'b0;
    logic [2*N*N-1:0] board;
    logic [3:0] pxo, pyo;
    logic [1:0] status;
    logic cur, busy, illegal;

    gomoku_turn_ctrl #(.BOARD_DIM(N), .WIN_LEN(5)) dut (
        .Clck(Clck), .Reset(Reset), .btn_left(bl), .btn_right(br), .btn_up(bu),
        .btn_down(bd), .btn_place(bp), .board(board), .pointer_loc_x(pxo),
        .pointer_loc_y(pyo), .gaming_status(status), .current_player(cur),
        .busy(busy), .illegal(illegal)
    );

    always #5 Clck = ~Clck;

    int total = 0, bad = 0;
    int mb[N][N];
    int mx, my, mst, mpl, mmoves, m_cyc;
    bit m_busy, m_ill, go;
    int pin_req = 0, pin_done = 0, pin_sel, pin_idx, pin_exp;
    string pin_name;

    function automatic int run_len(int x, int y, int dx, int dy, int p);
        int n = 0;
        int cx = x + dx;
        int cy = y + dy;
        while (cx >= 0 && cx < N && cy >= 0 && cy < N && mb[cx][cy] == p) begin
            n++;
            cx += dx;
            cy += dy;
        end
        return n;
    endfunction

    function automatic logic [2*N*N-1:0] flat();
        logic [2*N*N-1:0] v = '0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                v[2*(x+N*y) +: 2] = 2'(mb[x][y]);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Compare, then fold in the inputs the DUT will sample at the next rising edge.
    always @(negedge Clck) begin
        int p;
        bit win;
        if (go) begin
            chk("illegal", 512'(illegal), 512'(m_ill));
            if (m_busy) begin
                if (m_cyc == 0) chk("busy_rise", 512'(busy), 512'(1));
                m_cyc++;
                if (!busy) m_busy = 0;
                else if (m_cyc >= 42) begin
                    chk("latency", 512'(busy), 512'(0));
                    m_busy = 0;
                end
            end
            if (!m_busy) begin
                chk("board", board, flat());
                chk("cursor_x", 512'(pxo), 512'(mx));
                chk("cursor_y", 512'(pyo), 512'(my));
                chk("status", 512'(status), 512'(mst));
                chk("player", 512'(cur), 512'(mpl));
                chk("busy_idle", 512'(busy), 512'(0));
            end
            if (pin_req != pin_done) begin
                case (pin_sel)
                    0: chk(pin_name, 512'(board[2*pin_idx +: 2]), 512'(pin_exp));
                    1: chk(pin_name, 512'(pxo), 512'(pin_exp));
                    2: chk(pin_name, 512'(pyo), 512'(pin_exp));
                    3: chk(pin_name, 512'(status), 512'(pin_exp));
                    4: chk(pin_name, 512'(cur), 512'(pin_exp));
                    default: begin
                        chk("rst_board", board, 512'(0));
                        chk("rst_x", 512'(pxo), 512'(7));
                        chk("rst_y", 512'(pyo), 512'(7));
                        chk("rst_status", 512'(status), 512'(0));
                        chk("rst_player", 512'(cur), 512'(0));
                        chk("rst_busy", 512'(busy), 512'(0));
                    end
                endcase
                pin_done = pin_req;
            end
        end
        m_ill = 0;
        if (!Reset) begin
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++) mb[x][y] = 0;
            mx = 7; my = 7; mst = 0; mpl = 0; mmoves = 0; m_busy = 0;
        end else if (!m_busy && mst == 0) begin
            if (bp) begin
                if (mb[mx][my] != 0) m_ill = 1;
                else begin
                    p = mpl + 1;
                    mb[mx][my] = p;
                    mmoves++;
                    win = (1 + run_len(mx, my, 1, 0, p) + run_len(mx, my, -1, 0, p) >= 5) ||
                          (1 + run_len(mx, my, 0, 1, p) + run_len(mx, my, 0, -1, p) >= 5) ||
                          (1 + run_len(mx, my, 1, 1, p) + run_len(mx, my, -1, -1, p) >= 5) ||
                          (1 + run_len(mx, my, 1, -1, p) + run_len(mx, my, -1, 1, p) >= 5);
                    if (win) mst = p;
                    else if (mmoves == N*N) mst = 3;
                    else mpl = 1 - mpl;
                    m_busy = 1;
                    m_cyc = 0;
                end
            end else if (bl) begin if (mx > 0) mx--; end
            else if (br) begin if (mx < N-1) mx++; end
            else if (bu) begin if (my > 0) my--; end
            else if (bd) begin if (my < N-1) my++; end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 200 && m_busy; n++) @(posedge Clck);
    endtask

    task automatic press(input logic [4:0] b);
        wait_idle();
        @(posedge Clck); #1 {bp, bd, bu, br, bl} = b;
        @(posedge Clck); #1 {bp, bd, bu, br, bl} = 5'b0;
    endtask

    task automatic go_to(input int x, input int y);
        for (int i = 0; i < 40 && (mx != x || my != y); i++) begin
            if (mx > x) press(LEFT);
            else if (mx < x) press(RIGHT);
            else if (my > y) press(UP);
            else press(DOWN);
        end
    endtask

    task automatic place_at(input int x, input int y);
        go_to(x, y);
        press(PLACE);
    endtask

    task automatic do_reset();
        @(posedge Clck); #1 Reset = 1'b0;
        @(posedge Clck); #1 Reset = 1'b1;
    endtask

    task automatic pin(input int sel, input int idx, input int exp, input string nm);
        wait_idle();
        pin_sel = sel; pin_idx = idx; pin_exp = exp; pin_name = nm;
        pin_req++;
        for (int i = 0; i < 10 && pin_done != pin_req; i++) @(negedge Clck);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ax[$], ay[$], bx[$], by[$];
        repeat (2) @(posedge Clck);
        #1 Reset = 1'b1;
        go = 1;
        pin(5, 0, 0, "reset0");

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) press(PLACE);
            else press(5'($urandom_range(1, 15)));
        end
        do_reset();
        pin(5, 0, 0, "reset_after_random");

        repeat (10) press(LEFT);
        repeat (10) press(UP);
        pin(1, 0, 0, "clamp_x0");
        pin(2, 0, 0, "clamp_y0");
        repeat (20) press(RIGHT);
        pin(1, 0, 15, "clamp_x15");
        press(LEFT | RIGHT);
        pin(1, 0, 14, "left_over_right");

        do_reset();
        press(PLACE);
        pin(0, 119, 1, "first_stone");
        pin(4, 0, 1, "p2_to_move");
        press(PLACE);
        pin(0, 119, 1, "occupied_kept");
        pin(4, 0, 1, "illegal_no_toggle");

        do_reset();
        for (int i = 0; i < 4; i++) begin
            place_at(11 + i, 0);
            place_at(11 + i, 1);
        end
        place_at(15, 0);
        pin(3, 0, 1, "hwin_p1");
        pin(4, 0, 0, "hwin_no_toggle");
        press(LEFT); press(PLACE); press(DOWN);
        pin(1, 0, 15, "over_frozen_x");
        pin(3, 0, 1, "over_frozen_status");

        do_reset();
        place_at(8, 0);   place_at(4, 4);
        place_at(0, 15);  place_at(5, 3);
        place_at(10, 10); place_at(6, 2);
        place_at(12, 12); place_at(7, 1);
        place_at(14, 10); place_at(3, 5);
        pin(3, 0, 2, "adiag_p2");
        pin(0, 8, 1, "edge_stone_p1");
        pin(4, 0, 1, "adiag_no_toggle");

        do_reset();
        press(PLACE);
        @(posedge Clck); #1 Reset = 1'b0;
        @(posedge Clck); #1 Reset = 1'b1;
        pin(5, 0, 0, "reset_midscan");

        do_reset();
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                if (((x + 2*y) % 4) < 2) begin ax.push_back(x); ay.push_back(y); end
                else begin bx.push_back(x); by.push_back(y); end
        for (int i = 0; i < 128; i++) begin
            place_at(ax[i], ay[i]);
            place_at(bx[i], by[i]);
        end
        pin(3, 0, 3, "draw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
